// File: rtl/ifu_idu_buf_pkg.sv
// ifu_idu_buf_pkg: shared opcodes, buffer states and entry type for the fetch-to-decode buffer
package ifu_idu_buf_pkg;
  localparam int XLEN = 64;
  localparam int ILEN = 32;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;
  localparam logic [6:0] OPC_JAL = 7'b1101111;
  localparam logic [6:0] OPC_JALR = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_ONE = 2'd1,
    BUF_TWO = 2'd2
  } buf_state_t;
  typedef struct packed {
    logic [ILEN-1:0] inst;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] snpc;
    logic is_ctrl;
  } buf_entry_t;
  function automatic logic is_ctrl_op(input logic [6:0] opc);
    return (opc == OPC_JAL) || (opc == OPC_JALR) || (opc == OPC_BRANCH);
  endfunction
endpackage

// File: rtl/ifu_idu_buf_if.sv
// ifu_idu_buf_if: fetch-side and decode-side handshake bundle; slave is the buffer, master the environment
interface ifu_idu_buf_if #(
  parameter int XLEN = 64,
  parameter int ILEN = 32
);
  logic in_valid;
  logic in_ready;
  logic [ILEN-1:0] in_inst;
  logic [XLEN-1:0] in_pc;
  logic [XLEN-1:0] in_snpc;
  logic flush;
  logic out_valid;
  logic out_ready;
  logic [ILEN-1:0] out_inst;
  logic [XLEN-1:0] out_pc;
  logic [XLEN-1:0] out_snpc;
  logic out_is_ctrl;
  logic [1:0] count;
  modport slave (
    input in_valid, in_inst, in_pc, in_snpc, flush, out_ready,
    output in_ready, out_valid, out_inst, out_pc, out_snpc, out_is_ctrl, count
  );
  modport master (
    output in_valid, in_inst, in_pc, in_snpc, flush, out_ready,
    input in_ready, out_valid, out_inst, out_pc, out_snpc, out_is_ctrl, count
  );
endinterface

// File: rtl/ifu_idu_buf_inst_predecode.sv
// inst_predecode: flags jal/jalr/branch from the opcode field
module inst_predecode
  import ifu_idu_buf_pkg::*;
(
  input  logic [6:0] opc,
  output logic       is_ctrl
);
  assign is_ctrl = is_ctrl_op(opc);
endmodule

// File: rtl/ifu_idu_buf.sv
// ifu_idu_buf: 2-entry skid buffer between fetch and decode with control-flow predecode and flush
module ifu_idu_buf #(
  parameter int XLEN = 64,
  parameter int ILEN = 32,
  parameter logic [ILEN-1:0] NOP_INST = ifu_idu_buf_pkg::NOP_INST
) (
  input logic clk,
  input logic rst,
  ifu_idu_buf_if.slave bus
);
  import ifu_idu_buf_pkg::*;
  typedef struct packed {
    logic [ILEN-1:0] inst;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] snpc;
    logic is_ctrl;
  } ent_t;
  buf_state_t st, st_nx;
  ent_t main_q, skid_q, in_ent;
  logic in_ready, out_valid, in_fire, out_fire, pd;
  logic main_ld, skid_ld, shift;
  inst_predecode u_pd (.opc(bus.in_inst[6:0]), .is_ctrl(pd));
  assign in_ent = '{inst: bus.in_inst, pc: bus.in_pc, snpc: bus.in_snpc, is_ctrl: pd};
  assign in_ready = st != BUF_TWO;
  assign out_valid = st != BUF_EMPTY;
  assign in_fire = bus.in_valid & in_ready;
  assign out_fire = out_valid & bus.out_ready;
  always_comb begin
    st_nx = st;
    main_ld = 1'b0;
    skid_ld = 1'b0;
    shift = 1'b0;
    case (st)
      BUF_EMPTY: begin
        st_nx = in_fire ? BUF_ONE : BUF_EMPTY;
        main_ld = in_fire;
      end
      BUF_ONE: begin
        st_nx = in_fire ? (out_fire ? BUF_ONE : BUF_TWO) : (out_fire ? BUF_EMPTY : BUF_ONE);
        main_ld = in_fire & out_fire;
        skid_ld = in_fire & ~out_fire;
      end
      BUF_TWO: begin
        st_nx = out_fire ? BUF_ONE : BUF_TWO;
        shift = out_fire;
      end
      default: st_nx = BUF_EMPTY;
    endcase
    // redirect drops everything, including a same-cycle fetch
    if (bus.flush) begin
      st_nx = BUF_EMPTY;
      main_ld = 1'b0;
      skid_ld = 1'b0;
      shift = 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      st <= BUF_EMPTY;
      main_q <= '0;
      skid_q <= '0;
    end else begin
      st <= st_nx;
      if (main_ld) main_q <= in_ent;
      else if (shift) main_q <= skid_q;
      if (skid_ld) skid_q <= in_ent;
    end
  end
  assign bus.in_ready = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_inst = out_valid ? main_q.inst : NOP_INST;
  assign bus.out_pc = main_q.pc;
  assign bus.out_snpc = main_q.snpc;
  assign bus.out_is_ctrl = out_valid & main_q.is_ctrl;
  assign bus.count = st;
endmodule

// File: tb/tb_ifu_idu_buf.sv
// tb_ifu_idu_buf: directed checks of reset, handshake, backpressure, flush and streaming
module tb_ifu_idu_buf;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int errors = 0;
  int checks = 0;
  ifu_idu_buf_if #(.XLEN(64), .ILEN(32)) bus ();
  ifu_idu_buf dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic offer(input logic v, input logic [31:0] inst, input logic [63:0] pc);
    bus.in_valid = v;
    bus.in_inst = inst;
    bus.in_pc = pc;
    bus.in_snpc = pc + 64'd4;
  endtask
  initial begin
    bus.flush = 1'b0;
    bus.out_ready = 1'b0;
    offer(1'b1, 32'h00500093, 64'h80000000);
    tick();
    tick();
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_out_inst", 64'(bus.out_inst), 64'h13);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst_count", 64'(bus.count), 64'd0);
    chk("rst_out_pc", bus.out_pc, 64'd0);
    chk("rst_is_ctrl", 64'(bus.out_is_ctrl), 64'd0);
    rst = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    chk("single_valid", 64'(bus.out_valid), 64'd1);
    chk("single_inst", 64'(bus.out_inst), 64'h00500093);
    chk("single_pc", bus.out_pc, 64'h80000000);
    chk("single_snpc", bus.out_snpc, 64'h80000004);
    chk("single_is_ctrl", 64'(bus.out_is_ctrl), 64'd0);
    chk("single_count", 64'(bus.count), 64'd1);
    offer(1'b0, 32'h0, 64'h0);
    tick();
    chk("empty_valid", 64'(bus.out_valid), 64'd0);
    chk("empty_inst", 64'(bus.out_inst), 64'h13);
    chk("empty_pc_hold", bus.out_pc, 64'h80000000);
    chk("empty_count", 64'(bus.count), 64'd0);
    bus.out_ready = 1'b0;
    offer(1'b1, 32'h0000006f, 64'h80000000);
    tick();
    chk("bp_count1", 64'(bus.count), 64'd1);
    offer(1'b1, 32'h00100113, 64'h80000004);
    tick();
    chk("bp_count2", 64'(bus.count), 64'd2);
    chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
    chk("bp_inst", 64'(bus.out_inst), 64'h0000006f);
    chk("bp_is_ctrl", 64'(bus.out_is_ctrl), 64'd1);
    offer(1'b1, 32'h00200193, 64'h80000008);
    tick();
    chk("bp_third_count", 64'(bus.count), 64'd2);
    chk("bp_third_inst", 64'(bus.out_inst), 64'h0000006f);
    chk("bp_third_pc", bus.out_pc, 64'h80000000);
    offer(1'b0, 32'h0, 64'h0);
    bus.out_ready = 1'b1;
    tick();
    chk("drain1_inst", 64'(bus.out_inst), 64'h00100113);
    chk("drain1_pc", bus.out_pc, 64'h80000004);
    chk("drain1_snpc", bus.out_snpc, 64'h80000008);
    chk("drain1_is_ctrl", 64'(bus.out_is_ctrl), 64'd0);
    chk("drain1_in_ready", 64'(bus.in_ready), 64'd1);
    chk("drain1_count", 64'(bus.count), 64'd1);
    tick();
    chk("drain2_count", 64'(bus.count), 64'd0);
    chk("drain2_valid", 64'(bus.out_valid), 64'd0);
    bus.out_ready = 1'b0;
    offer(1'b1, 32'h0000006f, 64'h80000000);
    tick();
    offer(1'b1, 32'h00000063, 64'h80000004);
    tick();
    chk("refill_count", 64'(bus.count), 64'd2);
    offer(1'b1, 32'h00000013, 64'h80000008);
    bus.flush = 1'b1;
    tick();
    chk("flush2_count", 64'(bus.count), 64'd0);
    chk("flush2_valid", 64'(bus.out_valid), 64'd0);
    chk("flush2_in_ready", 64'(bus.in_ready), 64'd1);
    chk("flush2_inst", 64'(bus.out_inst), 64'h13);
    bus.flush = 1'b0;
    offer(1'b0, 32'h0, 64'h0);
    tick();
    chk("flush2_after_valid", 64'(bus.out_valid), 64'd0);
    offer(1'b1, 32'h00500093, 64'h90000000);
    tick();
    chk("flush1_pre_count", 64'(bus.count), 64'd1);
    offer(1'b1, 32'h00000067, 64'h90000004);
    bus.flush = 1'b1;
    tick();
    chk("flush1_count", 64'(bus.count), 64'd0);
    chk("flush1_valid", 64'(bus.out_valid), 64'd0);
    bus.flush = 1'b0;
    offer(1'b0, 32'h0, 64'h0);
    tick();
    chk("flush1_after_count", 64'(bus.count), 64'd0);
    chk("flush1_pc_hold", bus.out_pc, 64'h90000000);
    bus.out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      logic [31:0] inst;
      logic [63:0] pc;
      inst = (k == 3) ? 32'h000080e7 : (32'h00000093 | (32'(k) << 20));
      pc = 64'h80000000 + 64'(4 * k);
      offer(1'b1, inst, pc);
      tick();
      chk($sformatf("stream%0d_inst", k), 64'(bus.out_inst), 64'(inst));
      chk($sformatf("stream%0d_pc", k), bus.out_pc, pc);
      chk($sformatf("stream%0d_snpc", k), bus.out_snpc, pc + 64'd4);
      chk($sformatf("stream%0d_is_ctrl", k), 64'(bus.out_is_ctrl), (k == 3) ? 64'd1 : 64'd0);
      chk($sformatf("stream%0d_count", k), 64'(bus.count), 64'd1);
      chk($sformatf("stream%0d_in_ready", k), 64'(bus.in_ready), 64'd1);
    end
    offer(1'b0, 32'h0, 64'h0);
    tick();
    chk("stream_end_count", 64'(bus.count), 64'd0);
    bus.out_ready = 1'b0;
    offer(1'b1, 32'h00000063, 64'ha0000000);
    tick();
    tick();
    chk("midrst_pre_count", 64'(bus.count), 64'd2);
    rst = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    chk("midrst_count", 64'(bus.count), 64'd0);
    chk("midrst_inst", 64'(bus.out_inst), 64'h13);
    chk("midrst_pc", bus.out_pc, 64'd0);
    chk("midrst_in_ready", 64'(bus.in_ready), 64'd1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
